// File: rtl/osd_ram_pkg.sv
// Shared constants and pipeline owner tags for the OSD BRAM window.
// Default widths match the SPI address map and the on-chip OSD buffer.
// The owner enum tags each BRAM access so returning data is steered correctly.
package osd_ram_pkg;

  localparam int unsigned C_ADDR_BITS     = 32;
  localparam int unsigned C_RAM_ADDR_BITS = 12;
  localparam logic [7:0]  C_ADDR_OSD      = 8'hFD;
  localparam int unsigned C_STARVE_MAX    = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_SPI  = 2'd2
  } owner_t;

endpackage

// File: rtl/osd_ram_arbiter.sv
// Shares one single-port BRAM between a video read port and an SPI byte window.
// Latency: grant in cycle N -> BRAM access in N+1 -> read data returned in N+2.
// Video has priority; a held SPI request wins after c_starve_max lost cycles, extra SPI hits are dropped.
module osd_ram_arbiter
  import osd_ram_pkg::*;
#(
  parameter int unsigned c_addr_bits     = C_ADDR_BITS,
  parameter int unsigned c_ram_addr_bits = C_RAM_ADDR_BITS,
  parameter logic [7:0]  c_addr_osd      = C_ADDR_OSD,
  parameter int unsigned c_starve_max    = C_STARVE_MAX
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       spi_rd,
  input  logic                       spi_wr,
  input  logic [c_addr_bits-1:0]     spi_addr,
  input  logic [7:0]                 spi_wdata,
  output logic [7:0]                 spi_rdata,
  input  logic                       vid_req,
  input  logic [c_ram_addr_bits-1:0] vid_addr,
  output logic                       vid_gnt,
  output logic                       vid_valid,
  output logic [7:0]                 vid_rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [c_ram_addr_bits-1:0] ram_addr,
  output logic [7:0]                 ram_wdata,
  input  logic [7:0]                 ram_rdata,
  output logic                       overrun
);

  localparam int unsigned   CW         = $clog2(c_starve_max + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(c_starve_max);

  logic                       spi_hit;
  logic                       spi_pend;
  logic                       spi_we_q;
  logic [c_ram_addr_bits-1:0] spi_addr_q;
  logic [7:0]                 spi_wdata_q;
  logic [7:0]                 spi_rdata_q;
  logic [CW-1:0]              starve_cnt;
  logic                       vid_win;
  logic                       spi_win;
  logic                       spi_load;
  owner_t                     tag1;
  owner_t                     tag2;

  // Address bits between the window byte and the BRAM offset are don't-care.
  logic unused_addr;
  assign unused_addr = ^spi_addr[c_addr_bits-9:c_ram_addr_bits];

  // Window decode and single-cycle arbitration between video and the held SPI request.
  always_comb begin
    spi_hit  = (spi_rd | spi_wr) && (spi_addr[c_addr_bits-1 -: 8] == c_addr_osd);
    vid_win  = vid_req && (!spi_pend || (starve_cnt < STARVE_MAX));
    spi_win  = spi_pend && !vid_win;
    // A hit is only accepted into a free slot, or into the slot being vacated this cycle.
    spi_load = spi_hit && (!spi_pend || spi_win);
    vid_gnt  = vid_win && !reset;
  end

  // Held SPI request, sticky overrun flag and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_pend    <= 1'b0;
      spi_we_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      overrun     <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      if (spi_load) begin
        spi_pend    <= 1'b1;
        spi_we_q    <= spi_wr;  // read+write together counts as a write
        spi_addr_q  <= spi_addr[c_ram_addr_bits-1:0];
        spi_wdata_q <= spi_wdata;
      end else if (spi_win) begin
        spi_pend <= 1'b0;
      end
      if (spi_hit && !spi_load) begin
        overrun <= 1'b1;
      end
      if (spi_win) begin
        starve_cnt <= '0;
      end else if (spi_pend && (starve_cnt < STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  // Registered BRAM port plus the two-stage owner tag that tracks read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag1      <= OWN_NONE;
      tag2      <= OWN_NONE;
    end else begin
      ram_en <= vid_win | spi_win;
      ram_we <= spi_win & spi_we_q;
      if (vid_win) begin
        ram_addr <= vid_addr;
        tag1     <= OWN_VID;
      end else if (spi_win) begin
        ram_addr  <= spi_addr_q;
        ram_wdata <= spi_wdata_q;
        tag1      <= OWN_SPI;
      end else begin
        tag1 <= OWN_NONE;
      end
      // Writes return nothing, so they leave the data stage empty.
      tag2 <= (tag1 == OWN_SPI && ram_we) ? OWN_NONE : tag1;
    end
  end

  // Holds the last SPI read byte until the next SPI read returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_rdata_q <= '0;
    end else if (tag2 == OWN_SPI) begin
      spi_rdata_q <= ram_rdata;
    end
  end

  // Steer returning BRAM data; returns landing during reset are discarded.
  always_comb begin
    vid_valid = (tag2 == OWN_VID) && !reset;
    vid_rdata = vid_valid ? ram_rdata : 8'h00;
    spi_rdata = ((tag2 == OWN_SPI) && !reset) ? ram_rdata : spi_rdata_q;
  end

endmodule

// File: tb/tb_osd_ram_arbiter.sv
// Bench for osd_ram_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a cycle-scheduled reference model.
// A behavioural BRAM answers one cycle after each enabled read.
module tb_osd_ram_arbiter;
  import osd_ram_pkg::*;

  localparam logic F = 1'b0;
  localparam logic T = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_rd, spi_wr;
  logic [31:0] spi_addr;
  logic [7:0]  spi_wdata, spi_rdata;
  logic        vid_req, vid_gnt, vid_valid;
  logic [11:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        ram_en, ram_we, overrun;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  osd_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .overrun(overrun)
  );

  // Behavioural single-port BRAM.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: expected BRAM accesses and data returns are scheduled by cycle.
  logic [7:0]  ref_mem [0:4095];
  logic        sl_en [4], sl_we [4], sl_vret [4], sl_sret [4];
  logic [11:0] sl_addr [4];
  logic [7:0]  sl_wd [4], sl_val [4];
  logic        m_pend, m_we, m_ovr;
  logic [11:0] m_addr;
  logic [7:0]  m_wd, m_spi;
  int          m_starve;

  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [7:0] d, input logic vq, input logic [11:0] va);
    int   s, n1, n2;
    logic hit, vw, sw;
    @(negedge clk);
    reset = r; spi_rd = rd; spi_wr = wr; spi_addr = a; spi_wdata = d; vid_req = vq; vid_addr = va;
    #1;
    s  = cyc % 4;
    n1 = (cyc + 1) % 4;
    n2 = (cyc + 2) % 4;
    if (r) begin
      check("m_gnt_in_reset", vid_gnt, 0);
      m_pend = 0; m_starve = 0; m_ovr = 0; m_spi = 8'h00;
      for (int i = 0; i < 4; i++) begin
        sl_en[i] = 0; sl_vret[i] = 0; sl_sret[i] = 0;
      end
    end else begin
      check("m_ram_en", ram_en, sl_en[s]);
      if (sl_en[s]) begin
        check("m_ram_we", ram_we, sl_we[s]);
        check("m_ram_addr", ram_addr, sl_addr[s]);
        if (sl_we[s]) check("m_ram_wdata", ram_wdata, sl_wd[s]);
      end
      check("m_vid_valid", vid_valid, sl_vret[s]);
      if (sl_vret[s]) check("m_vid_rdata", vid_rdata, sl_val[s]);
      if (sl_sret[s]) m_spi = sl_val[s];
      check("m_spi_rdata", spi_rdata, m_spi);
      check("m_overrun", overrun, m_ovr);
      sl_en[s] = 0; sl_vret[s] = 0; sl_sret[s] = 0;

      hit = (rd | wr) && (a[31:24] == 8'hFD);
      vw  = vq && (!m_pend || m_starve < C_STARVE_MAX);
      sw  = m_pend && !vw;
      check("m_vid_gnt", vid_gnt, vw);
      if (vw) begin
        sl_en[n1] = 1; sl_we[n1] = 0; sl_addr[n1] = va;
        sl_vret[n2] = 1; sl_val[n2] = ref_mem[va];
      end else if (sw) begin
        sl_en[n1] = 1; sl_we[n1] = m_we; sl_addr[n1] = m_addr; sl_wd[n1] = m_wd;
        if (m_we) ref_mem[m_addr] = m_wd;
        else begin
          sl_sret[n2] = 1; sl_val[n2] = ref_mem[m_addr];
        end
      end
      if (sw) m_starve = 0;
      else if (m_pend && m_starve < C_STARVE_MAX) m_starve++;
      if (hit) begin
        if (!m_pend || sw) begin
          m_pend = 1; m_we = wr; m_addr = a[11:0]; m_wd = d;
        end else begin
          m_ovr = 1;
        end
      end else if (sw) begin
        m_pend = 0;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(F, F, F, 32'h0, 8'h00, F, 12'h000);
  endtask

  typedef struct {
    logic rd, wr; logic [31:0] addr; logic [7:0] wd; logic vreq; logic [11:0] vaddr;
    logic en, we; logic [11:0] a; logic [7:0] wdat; logic gnt, vv; logic [7:0] vdat, srd; logic ovr;
  } vec_t;

  vec_t        tbl [19];
  int          vg, first_idle, wcnt;
  logic        rr, rd_r, wr_r, vq_r;
  logic [31:0] a_r;
  logic [11:0] va_r;

  initial begin
    ram_rdata <= 8'h00;
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= pat(i);
      ref_mem[i] = pat(i);
    end
    reset = 1; spi_rd = 0; spi_wr = 0; spi_addr = 0; spi_wdata = 0; vid_req = 0; vid_addr = 0;

    //              rd wr addr          wd     vq vaddr    | en we a      wdat   gnt vv vdat   srd    ovr
    tbl[0]  = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[1]  = '{F, T, 32'hFD000010, 8'h5A, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[2]  = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[3]  = '{F, F, 32'h0,        8'h00, F, 12'h000, T, T, 12'h010, 8'h5A, F, F, 8'h00, 8'h00, F};
    tbl[4]  = '{T, F, 32'hFD000010, 8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[5]  = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[6]  = '{F, F, 32'h0,        8'h00, F, 12'h000, T, F, 12'h010, 8'h00, F, F, 8'h00, 8'h00, F};
    tbl[7]  = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[8]  = '{F, T, 32'hFB000000, 8'h77, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[9]  = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[10] = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[11] = '{F, F, 32'h0,        8'h00, T, 12'h010, F, F, 12'h000, 8'h00, T, F, 8'h00, 8'h5A, F};
    tbl[12] = '{F, F, 32'h0,        8'h00, F, 12'h000, T, F, 12'h010, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[13] = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, T, 8'h5A, 8'h5A, F};
    tbl[14] = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[15] = '{T, T, 32'hFD000011, 8'hC3, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[16] = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};
    tbl[17] = '{F, F, 32'h0,        8'h00, F, 12'h000, T, T, 12'h011, 8'hC3, F, F, 8'h00, 8'h5A, F};
    tbl[18] = '{F, F, 32'h0,        8'h00, F, 12'h000, F, F, 12'h000, 8'h00, F, F, 8'h00, 8'h5A, F};

    step(T, F, F, 32'h0, 8'h00, F, 12'h000);
    for (int i = 0; i < 19; i++) begin
      step(F, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].vreq, tbl[i].vaddr);
      check($sformatf("tbl[%0d].ram_en", i), ram_en, tbl[i].en);
      check($sformatf("tbl[%0d].ram_we", i), ram_we, tbl[i].we);
      if (tbl[i].en) check($sformatf("tbl[%0d].ram_addr", i), ram_addr, tbl[i].a);
      if (tbl[i].we) check($sformatf("tbl[%0d].ram_wdata", i), ram_wdata, tbl[i].wdat);
      check($sformatf("tbl[%0d].vid_gnt", i), vid_gnt, tbl[i].gnt);
      check($sformatf("tbl[%0d].vid_valid", i), vid_valid, tbl[i].vv);
      if (tbl[i].vv) check($sformatf("tbl[%0d].vid_rdata", i), vid_rdata, tbl[i].vdat);
      check($sformatf("tbl[%0d].spi_rdata", i), spi_rdata, tbl[i].srd);
      check($sformatf("tbl[%0d].overrun", i), overrun, tbl[i].ovr);
    end

    // Video saturates the BRAM; the SPI read must win after exactly four lost cycles.
    step(T, F, F, 32'h0, 8'h00, F, 12'h000);
    vg = 0; first_idle = -1;
    for (int c = 0; c < 12; c++) begin
      step(F, c == 0, F, 32'hFD000020, 8'h00, T, 12'h100 + 12'(c));
      if (c >= 1 && c <= 4 && vid_gnt) vg++;
      if (first_idle < 0 && c >= 1 && !vid_gnt) first_idle = c;
      if (c == 6) begin
        check("starve_resume_gnt", vid_gnt, 1);
        check("starve_spi_ram_en", ram_en, 1);
        check("starve_spi_ram_we", ram_we, 0);
        check("starve_spi_ram_addr", ram_addr, 12'h020);
      end
      if (c == 7) check("starve_spi_rdata", spi_rdata, pat(32'h20));
    end
    check("starve_vid_grants", vg, 4);
    check("starve_spi_slot", first_idle, 5);

    // Two back-to-back SPI hits under video load: second dropped, first completes.
    wcnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(F, F, c < 2, (c == 0) ? 32'hFD000030 : 32'hFD000031, (c == 0) ? 8'h11 : 8'h22, T, 12'h200);
      if (c == 1) check("ovr_before_drop", overrun, 0);
      if (c == 2) check("ovr_after_drop", overrun, 1);
      if (c == 6) check("ovr_first_write_slot", ram_we, 1);
      if (ram_en && ram_we) begin
        wcnt++;
        check("ovr_write_addr", ram_addr, 12'h030);
        check("ovr_write_data", ram_wdata, 8'h11);
      end
    end
    check("ovr_write_count", wcnt, 1);
    for (int c = 0; c < 3; c++) idle();
    check("ovr_sticky", overrun, 1);

    // Reset the cycle after a video grant: the return is discarded, outputs clear.
    step(F, F, F, 32'h0, 8'h00, T, 12'h040);
    check("rst_pre_gnt", vid_gnt, 1);
    step(T, F, F, 32'h0, 8'h00, T, 12'h040);
    check("rst_gnt_low", vid_gnt, 0);
    idle();
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_spi_rdata", spi_rdata, 0);
    check("rst_overrun", overrun, 0);
    idle();
    check("rst_no_late_valid", vid_valid, 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      rr   = ($urandom_range(0, 199) == 0);
      rd_r = ($urandom_range(0, 99) < 25);
      wr_r = ($urandom_range(0, 99) < 25);
      a_r  = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFD, 12'($urandom), 7'b0, 5'($urandom)};
      vq_r = ($urandom_range(0, 99) < 60);
      va_r = 12'($urandom_range(0, 31));
      step(rr, rd_r, wr_r, a_r, 8'($urandom), vq_r, va_r);
    end
    for (int k = 0; k < 4; k++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
